// File: rtl/gcd_if.sv
// rtl/gcd_if.sv - operand/result stream bundle for the GCD engine
interface gcd_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = WIDTH + 1
);
    logic                   in_valid;
    logic [2*WIDTH-1:0]     in_data;
    logic                   in_ready;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic [CNT_W-1:0]       out_cycles;

    // Producer of operands and consumer of results
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_cycles
    );

    // The engine itself
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_cycles
    );
endinterface

// File: rtl/gcd_engine.sv
// rtl/gcd_engine.sv - iterative GCD engine, subtractive Euclid or binary Stein
module gcd_engine #(
    parameter int WIDTH = 16,
    parameter int MODE  = 0,
    parameter int CNT_W = WIDTH + 1
) (
    input  logic  clk,
    input  logic  rst,
    gcd_if.slave  s
);
    // k never exceeds WIDTH-1, so clog2(WIDTH) bits always hold it
    localparam int KW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [KW-1:0]      k_q, k_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]   out_cycles_q, out_cycles_d;
    logic               out_valid_q, out_valid_d;

    logic               in_ready;
    logic               accept;
    logic               term;
    logic               a_gt_b;
    logic [WIDTH-1:0]   res;
    logic [WIDTH-1:0]   diff;
    logic [CNT_W-1:0]   cnt_inc;

    // Ready in IDLE, or in DONE when the result leaves this same edge
    assign in_ready     = (state_q == ST_IDLE) || ((state_q == ST_DONE) && s.out_ready);
    assign accept       = s.in_valid && in_ready;

    assign s.in_ready   = in_ready;
    assign s.out_valid  = out_valid_q;
    assign s.out_data   = out_data_q;
    assign s.out_cycles = out_cycles_q;

    // Next-state logic: termination test, one algorithm step, handshakes
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        k_d          = k_q;
        cnt_d        = cnt_q;
        out_data_d   = out_data_q;
        out_cycles_d = out_cycles_q;
        out_valid_d  = out_valid_q;

        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        a_gt_b  = (a_q > b_q);
        // Always larger minus smaller, so the subtraction never wraps
        diff    = a_gt_b ? (a_q - b_q) : (b_q - a_q);

        term = 1'b0;
        res  = '0;
        if (a_q == '0) begin
            term = 1'b1;
            res  = b_q;
        end else if (b_q == '0) begin
            term = 1'b1;
            res  = a_q;
        end else if (a_q == b_q) begin
            term = 1'b1;
            res  = a_q;
        end

        case (state_q)
            ST_IDLE: begin
            end
            ST_CALC: begin
                cnt_d = cnt_inc;
                if (term) begin
                    // k stays zero in Euclid mode, so the shift is a no-op there
                    out_data_d   = res << k_q;
                    out_cycles_d = cnt_inc;
                    out_valid_d  = 1'b1;
                    state_d      = ST_DONE;
                end else if (MODE == 0) begin
                    if (a_gt_b) a_d = diff;
                    else        b_d = diff;
                end else begin
                    if (!a_q[0] && !b_q[0]) begin
                        a_d = a_q >> 1;
                        b_d = b_q >> 1;
                        k_d = k_q + 1'b1;
                    end else if (!a_q[0]) begin
                        a_d = a_q >> 1;
                    end else if (!b_q[0]) begin
                        b_d = b_q >> 1;
                    end else if (a_gt_b) begin
                        a_d = diff;
                    end else begin
                        b_d = diff;
                    end
                end
            end
            ST_DONE: begin
                if (s.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new pair overrides the IDLE/DONE transition (back-to-back handoff)
        if (accept) begin
            a_d     = s.in_data[2*WIDTH-1:WIDTH];
            b_d     = s.in_data[WIDTH-1:0];
            k_d     = '0;
            cnt_d   = '0;
            state_d = ST_CALC;
        end
    end

    // State and registered outputs; reset aborts any calculation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            k_q          <= '0;
            cnt_q        <= '0;
            out_data_q   <= '0;
            out_cycles_q <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            k_q          <= k_d;
            cnt_q        <= cnt_d;
            out_data_q   <= out_data_d;
            out_cycles_q <= out_cycles_d;
            out_valid_q  <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_gcd_engine.sv
// tb/tb_gcd_engine.sv - directed and randomized checks of gcd_engine in both modes
module tb_gcd_engine;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sel = 1'b0;
    logic          in_valid = 1'b0;
    logic [2*W-1:0] in_data = '0;
    logic          out_ready = 1'b1;

    logic          obs_in_ready;
    logic          obs_out_valid;
    logic [W-1:0]  obs_out_data;
    logic [W:0]    obs_out_cycles;

    int total = 0;
    int bad   = 0;

    gcd_if #(.WIDTH(W)) if0 ();
    gcd_if #(.WIDTH(W)) if1 ();

    gcd_engine #(.WIDTH(W), .MODE(0)) u_euclid (.clk(clk), .rst(rst), .s(if0.slave));
    gcd_engine #(.WIDTH(W), .MODE(1)) u_stein  (.clk(clk), .rst(rst), .s(if1.slave));

    assign if0.in_valid  = in_valid & ~sel;
    assign if1.in_valid  = in_valid & sel;
    assign if0.in_data   = in_data;
    assign if1.in_data   = in_data;
    assign if0.out_ready = out_ready & ~sel;
    assign if1.out_ready = out_ready & sel;

    assign obs_in_ready   = sel ? if1.in_ready   : if0.in_ready;
    assign obs_out_valid  = sel ? if1.out_valid  : if0.out_valid;
    assign obs_out_data   = sel ? if1.out_data   : if0.out_data;
    assign obs_out_cycles = sel ? if1.out_cycles : if0.out_cycles;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int ref_cycles(input int mode, input int a, input int b);
        int n;
        n = 0;
        while (n < 200000) begin
            n++;
            if (a == 0 || b == 0 || a == b) break;
            if (mode == 0) begin
                if (a > b) a = a - b;
                else       b = b - a;
            end else begin
                if ((a % 2) == 0 && (b % 2) == 0) begin
                    a = a / 2;
                    b = b / 2;
                end else if ((a % 2) == 0) begin
                    a = a / 2;
                end else if ((b % 2) == 0) begin
                    b = b / 2;
                end else if (a > b) begin
                    a = a - b;
                end else begin
                    b = b - a;
                end
            end
        end
        return n;
    endfunction

    // Issue one pair from IDLE, wait for the result, optionally stall the consumer,
    // then retire it; returns at a negedge with the selected engine back in IDLE.
    task automatic run_pair(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                            output int res, output int cyc, output int lat);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        in_data   = {a, b};
        @(negedge clk);
        in_valid  = 1'b0;
        lat = 1;
        while (!obs_out_valid && lat < 70000) begin
            @(negedge clk);
            lat++;
        end
        if (!obs_out_valid) chk("result_timeout", 32'd0, 32'd1);
        res = int'(obs_out_data);
        cyc = int'(obs_out_cycles);
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            out_ready = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        int res, cyc, lat, ra, rb, hold, n;

        // Reset and reset-state checks
        sel = 1'b0;
        out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", 32'(obs_out_valid), 32'd0);
        chk("rst_in_ready", 32'(obs_in_ready), 32'd1);
        chk("rst_out_data", 32'(obs_out_data), 32'd0);
        chk("rst_out_cycles", 32'(obs_out_cycles), 32'd0);

        // Euclid: gcd(48,32)
        run_pair(16'h0030, 16'h0020, 0, res, cyc, lat);
        chk("m0_48_32_data", res, 32'h10);
        chk("m0_48_32_cycles", cyc, 32'd3);
        chk("m0_48_32_latency", lat, 32'd4);

        // Stein: gcd(48,32) and gcd(7,5)
        sel = 1'b1;
        run_pair(16'h0030, 16'h0020, 0, res, cyc, lat);
        chk("m1_48_32_data", res, 32'h10);
        chk("m1_48_32_cycles", cyc, 32'd8);
        chk("m1_48_32_latency", lat, 32'd9);
        run_pair(16'h0007, 16'h0005, 0, res, cyc, lat);
        chk("m1_7_5_data", res, 32'd1);
        chk("m1_7_5_cycles", cyc, 32'd6);
        run_pair(16'h0000, 16'h0000, 0, res, cyc, lat);
        chk("m1_0_0_data", res, 32'd0);

        // Zero operands in Euclid mode
        sel = 1'b0;
        run_pair(16'h0000, 16'h0009, 0, res, cyc, lat);
        chk("m0_0_9_data", res, 32'd9);
        chk("m0_0_9_cycles", cyc, 32'd1);
        run_pair(16'h000C, 16'h0000, 0, res, cyc, lat);
        chk("m0_c_0_data", res, 32'hC);
        chk("m0_c_0_cycles", cyc, 32'd1);
        run_pair(16'h0000, 16'h0000, 0, res, cyc, lat);
        chk("m0_0_0_data", res, 32'd0);

        // Backpressure, then same-edge handoff of a waiting pair
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = {16'h0030, 16'h0020};
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!obs_out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1;
        in_data  = {16'h0015, 16'h000E};
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_out_valid", 32'(obs_out_valid), 32'd1);
            chk("bp_out_data", 32'(obs_out_data), 32'h10);
            chk("bp_out_cycles", 32'(obs_out_cycles), 32'd3);
            chk("bp_in_ready", 32'(obs_in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("handoff_in_ready", 32'(obs_in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("handoff_out_valid_drop", 32'(obs_out_valid), 32'd0);
        lat = 1;
        while (!obs_out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("handoff_data", 32'(obs_out_data), 32'd7);
        chk("handoff_cycles", 32'(obs_out_cycles), 32'd3);
        chk("handoff_latency", lat, 32'd4);
        @(negedge clk);

        // Reset in the middle of a long Euclid run
        in_valid = 1'b1;
        in_data  = {16'h0001, 16'hFFFF};
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_out_valid", 32'(obs_out_valid), 32'd0);
        chk("midrst_in_ready", 32'(obs_in_ready), 32'd1);
        repeat (20) @(negedge clk);
        chk("midrst_no_result", 32'(obs_out_valid), 32'd0);
        run_pair(16'h0030, 16'h0020, 0, res, cyc, lat);
        chk("post_rst_data", res, 32'h10);
        chk("post_rst_cycles", cyc, 32'd3);

        // Randomized pairs with random consumer stalls, both modes
        for (int m = 0; m < 2; m++) begin
            sel = (m == 1);
            for (int i = 0; i < 40; i++) begin
                if (m == 0) begin
                    ra = int'($urandom_range(0, 255));
                    rb = int'($urandom_range(0, 255));
                end else begin
                    ra = int'($urandom_range(0, 65535));
                    rb = int'($urandom_range(0, 65535));
                end
                hold = int'($urandom_range(0, 3));
                run_pair(W'(ra), W'(rb), hold, res, cyc, lat);
                chk($sformatf("rnd_m%0d_data_%0h_%0h", m, ra, rb), res, ref_gcd(ra, rb));
                chk($sformatf("rnd_m%0d_cycles_%0h_%0h", m, ra, rb), cyc, ref_cycles(m, ra, rb));
                chk($sformatf("rnd_m%0d_latency_%0h_%0h", m, ra, rb), lat, ref_cycles(m, ra, rb) + 1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
